rx_sequencer: RTL and testbench

Receive frame sequencer between the synchronization block and the receive AXI-Stream master port. It arms on a configuration enable and waits for a frame-detect strobe. It then forwards exactly `frame_len` samples with `tlast` on the final beat, counts completed frames, flags output overflow and raises a level interrupt for the control register file.

---
 rtl/rx_sequencer.sv | 155 +++++++++++++++
 tb/tb_rx_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_sequencer.sv
// Receive frame sequencer: arms on enable, waits for a frame-detect strobe, forwards a
// fixed-length frame onto a single-beat AXI-Stream output register with tlast, overflow and irq.
module rx_sequencer #(
  parameter int unsigned LEN_WIDTH   = 12,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [LEN_WIDTH-1:0]   frame_len,
  input  logic                   irq_clear,
  input  logic                   s_valid,
  input  logic [31:0]            s_data,
  input  logic                   s_start,
  output logic                   m_axis_tvalid,
  output logic [31:0]            m_axis_tdata,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready,
  output logic                   busy,
  output logic                   overflow,
  output logic [COUNT_WIDTH-1:0] frame_count,
  output logic                   irq
);

  typedef enum logic [1:0] {StIdle, StArmed, StCapture, StDrain} state_e;

  state_e                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   tvalid_q, tvalid_d;
  logic [31:0]            tdata_q, tdata_d;
  logic                   tlast_q, tlast_d;
  logic                   busy_q, busy_d;
  logic                   overflow_q, overflow_d;
  logic [COUNT_WIDTH-1:0] frame_count_q, frame_count_d;
  logic                   irq_q, irq_d;

  logic                 slot_free;
  logic                 handshake;
  logic                 last_hs;
  logic                 drop;
  logic [LEN_WIDTH-1:0] start_len;
  logic [LEN_WIDTH-1:0] cnt_inc;

  assign slot_free = !tvalid_q || m_axis_tready;
  assign handshake = tvalid_q && m_axis_tready;
  assign last_hs   = handshake && tlast_q;
  assign start_len = (frame_len == '0) ? LEN_WIDTH'(1) : frame_len;
  assign cnt_inc   = cnt_q + LEN_WIDTH'(1);

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    tvalid_d      = tvalid_q;
    tdata_d       = tdata_q;
    tlast_d       = tlast_q;
    overflow_d    = overflow_q;
    frame_count_d = frame_count_q;
    drop          = 1'b0;

    // A beat leaving this cycle frees the register; a load below re-fills it with no bubble.
    if (handshake) begin
      tvalid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StArmed;
        end
      end
      StArmed: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (s_valid && s_start) begin
          len_d    = start_len;
          cnt_d    = LEN_WIDTH'(1);
          tvalid_d = 1'b1;
          tdata_d  = s_data;
          tlast_d  = (start_len == LEN_WIDTH'(1));
          state_d  = (start_len == LEN_WIDTH'(1)) ? StDrain : StCapture;
        end
      end
      StCapture: begin
        if (s_valid) begin
          if (slot_free) begin
            cnt_d    = cnt_inc;
            tvalid_d = 1'b1;
            tdata_d  = s_data;
            tlast_d  = (cnt_inc == len_q);
            if (cnt_inc == len_q) begin
              state_d = StDrain;
            end
          end else begin
            drop       = 1'b1;
            overflow_d = 1'b1;
          end
        end
      end
      StDrain: begin
        if (last_hs) begin
          frame_count_d = frame_count_q + COUNT_WIDTH'(1);
          state_d       = enable ? StArmed : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StCapture) || (state_d == StDrain);

    if (last_hs || drop) begin
      irq_d = 1'b1;
    end else if (irq_clear) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      len_q         <= '0;
      cnt_q         <= '0;
      tvalid_q      <= 1'b0;
      tdata_q       <= '0;
      tlast_q       <= 1'b0;
      busy_q        <= 1'b0;
      overflow_q    <= 1'b0;
      frame_count_q <= '0;
      irq_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      tvalid_q      <= tvalid_d;
      tdata_q       <= tdata_d;
      tlast_q       <= tlast_d;
      busy_q        <= busy_d;
      overflow_q    <= overflow_d;
      frame_count_q <= frame_count_d;
      irq_q         <= irq_d;
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign busy          = busy_q;
  assign overflow      = overflow_q;
  assign frame_count   = frame_count_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_rx_sequencer.sv
// Directed self-checking bench for rx_sequencer: inputs change 1ns after posedge,
// outputs are observed 1ns after the following posedge.
module tb_rx_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [11:0] frame_len;
  logic        irq_clear;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_start;
  logic        m_axis_tvalid;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic        busy;
  logic        overflow;
  logic [15:0] frame_count;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  rx_sequencer #(.LEN_WIDTH(12), .COUNT_WIDTH(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .frame_len    (frame_len),
    .irq_clear    (irq_clear),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_start      (s_start),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .busy         (busy),
    .overflow     (overflow),
    .frame_count  (frame_count),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_irq();
    irq_clear = 1'b1;
    cycle();
    irq_clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; frame_len = 12'd4; irq_clear = 1'b0;
    s_valid = 1'b0; s_data = '0; s_start = 1'b0; m_axis_tready = 1'b1;
    repeat (3) cycle();
    reset = 1'b0;
    cycle();
    n_tests++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got=%b exp=0", m_axis_tvalid); end
    n_tests++; if (m_axis_tdata !== 32'h0) begin n_fail++; $display("FAIL reset_tdata got=%h exp=0", m_axis_tdata); end
    n_tests++; if (m_axis_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast got=%b exp=0", m_axis_tlast); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    n_tests++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL reset_fcount got=%0d exp=0", frame_count); end
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", irq); end
  endtask

  task automatic test_basic();
    logic [31:0] exp_d;
    enable = 1'b1; frame_len = 12'd4; m_axis_tready = 1'b1;
    cycle();
    for (int i = 0; i < 4; i++) begin
      exp_d = 32'hA000_0000 + 32'(i);
      s_valid = 1'b1; s_start = (i == 0); s_data = exp_d;
      cycle();
      n_tests++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_d) begin
        n_fail++; $display("FAIL basic_beat%0d valid=%b data=%h exp valid=1 data=%h", i, m_axis_tvalid, m_axis_tdata, exp_d); end
      n_tests++; if (m_axis_tlast !== (i == 3)) begin
        n_fail++; $display("FAIL basic_tlast%0d got=%b exp=%b", i, m_axis_tlast, (i == 3)); end
      n_tests++; if (busy !== 1'b1 && i > 0) begin n_fail++; $display("FAIL basic_busy%0d got=%b exp=1", i, busy); end
    end
    s_start = 1'b0; s_data = 32'hA000_0004;
    cycle();
    n_tests++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL basic_a4_fwd tvalid=%b exp=0", m_axis_tvalid); end
    n_tests++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL basic_fcount got=%0d exp=1", frame_count); end
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL basic_irq got=%b exp=1", irq); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end got=%b exp=0", busy); end
    s_data = 32'hA000_0005;
    cycle();
    s_valid = 1'b0;
    n_tests++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL basic_a5_fwd tvalid=%b exp=0", m_axis_tvalid); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL basic_overflow got=%b exp=0", overflow); end
    clear_irq();
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL basic_irq_clear got=%b exp=0", irq); end
  endtask

  task automatic test_len0();
    frame_len = 12'd0;
    s_valid = 1'b1; s_start = 1'b1; s_data = 32'hB000_0000;
    cycle();
    s_valid = 1'b0; s_start = 1'b0;
    n_tests++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'hB000_0000 || m_axis_tlast !== 1'b1) begin
      n_fail++; $display("FAIL len0_beat valid=%b data=%h last=%b exp 1/b0000000/1", m_axis_tvalid, m_axis_tdata, m_axis_tlast); end
    cycle();
    n_tests++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL len0_tvalid got=%b exp=0", m_axis_tvalid); end
    n_tests++; if (frame_count !== 16'd2) begin n_fail++; $display("FAIL len0_fcount got=%0d exp=2", frame_count); end
    clear_irq();
  endtask

  task automatic test_overflow();
    frame_len = 12'd3; m_axis_tready = 1'b0;
    s_valid = 1'b1; s_start = 1'b1; s_data = 32'hC000_0000;
    cycle();
    n_tests++; if (m_axis_tdata !== 32'hC000_0000 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_c0 data=%h ovf=%b exp c0000000/0", m_axis_tdata, overflow); end
    s_start = 1'b0; s_data = 32'hC000_0001;
    cycle();
    n_tests++; if (overflow !== 1'b1 || irq !== 1'b1) begin
      n_fail++; $display("FAIL ovf_drop ovf=%b irq=%b exp 1/1", overflow, irq); end
    n_tests++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'hC000_0000) begin
      n_fail++; $display("FAIL ovf_hold valid=%b data=%h exp 1/c0000000", m_axis_tvalid, m_axis_tdata); end
    m_axis_tready = 1'b1; s_data = 32'hC000_0002;
    cycle();
    n_tests++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'hC000_0002 || m_axis_tlast !== 1'b0) begin
      n_fail++; $display("FAIL ovf_c2 valid=%b data=%h last=%b exp 1/c0000002/0", m_axis_tvalid, m_axis_tdata, m_axis_tlast); end
    s_data = 32'hC000_0003;
    cycle();
    s_valid = 1'b0;
    n_tests++; if (m_axis_tdata !== 32'hC000_0003 || m_axis_tlast !== 1'b1) begin
      n_fail++; $display("FAIL ovf_c3 data=%h last=%b exp c0000003/1", m_axis_tdata, m_axis_tlast); end
    cycle();
    n_tests++; if (frame_count !== 16'd3 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_end fcount=%0d ovf=%b exp 3/1", frame_count, overflow); end
    clear_irq();
  endtask

  task automatic test_enable_drop();
    logic [31:0] exp_d;
    frame_len = 12'd8;
    for (int i = 0; i < 8; i++) begin
      exp_d = 32'hD000_0000 + 32'(i);
      s_valid = 1'b1; s_start = (i == 0); s_data = exp_d;
      cycle();
      if (i == 1) enable = 1'b0;
      n_tests++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_d || m_axis_tlast !== (i == 7)) begin
        n_fail++; $display("FAIL endrop_beat%0d valid=%b data=%h last=%b exp 1/%h/%b", i, m_axis_tvalid, m_axis_tdata, m_axis_tlast, exp_d, (i == 7)); end
    end
    s_valid = 1'b0; s_start = 1'b0;
    cycle();
    n_tests++; if (frame_count !== 16'd4 || busy !== 1'b0) begin
      n_fail++; $display("FAIL endrop_end fcount=%0d busy=%b exp 4/0", frame_count, busy); end
    s_valid = 1'b1; s_start = 1'b1; s_data = 32'hD000_00FF;
    cycle();
    s_valid = 1'b0; s_start = 1'b0;
    cycle();
    n_tests++; if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL endrop_idle valid=%b busy=%b exp 0/0", m_axis_tvalid, busy); end
    clear_irq();
  endtask

  task automatic test_irq_clear();
    enable = 1'b1; frame_len = 12'd1;
    cycle();
    s_valid = 1'b1; s_start = 1'b1; s_data = 32'hE000_0000;
    cycle();
    s_valid = 1'b0; s_start = 1'b0; irq_clear = 1'b1;
    n_tests++; if (m_axis_tlast !== 1'b1 || m_axis_tdata !== 32'hE000_0000) begin
      n_fail++; $display("FAIL irqclr_beat last=%b data=%h exp 1/e0000000", m_axis_tlast, m_axis_tdata); end
    cycle();
    n_tests++; if (irq !== 1'b1 || frame_count !== 16'd5) begin
      n_fail++; $display("FAIL irqclr_setwins irq=%b fcount=%0d exp 1/5", irq, frame_count); end
    cycle();
    irq_clear = 1'b0;
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irqclr_clear got=%b exp=0", irq); end
  endtask

  task automatic test_back_to_back();
    frame_len = 12'd2;
    s_valid = 1'b1; s_start = 1'b1; s_data = 32'h6000_0000;
    cycle();
    s_start = 1'b0; s_data = 32'h6000_0001;
    cycle();
    n_tests++; if (m_axis_tdata !== 32'h6000_0001 || m_axis_tlast !== 1'b1) begin
      n_fail++; $display("FAIL b2b_g1 data=%h last=%b exp 60000001/1", m_axis_tdata, m_axis_tlast); end
    s_valid = 1'b0;
    cycle();
    n_tests++; if (frame_count !== 16'd6 || m_axis_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_gap fcount=%0d valid=%b exp 6/0", frame_count, m_axis_tvalid); end
    s_valid = 1'b1; s_start = 1'b1; s_data = 32'h7000_0000;
    cycle();
    n_tests++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h7000_0000 || busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_h0 valid=%b data=%h busy=%b exp 1/70000000/1", m_axis_tvalid, m_axis_tdata, busy); end
    s_start = 1'b0; s_data = 32'h7000_0001;
    cycle();
    s_valid = 1'b0;
    cycle();
    n_tests++; if (frame_count !== 16'd7) begin n_fail++; $display("FAIL b2b_fcount got=%0d exp=7", frame_count); end
    clear_irq();
  endtask

  task automatic test_reset_mid();
    frame_len = 12'd4; m_axis_tready = 1'b0;
    s_valid = 1'b1; s_start = 1'b1; s_data = 32'hF000_0000;
    cycle();
    s_start = 1'b0; s_data = 32'hF000_0001;
    cycle();
    n_tests++; if (m_axis_tvalid !== 1'b1 || busy !== 1'b1 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre valid=%b busy=%b ovf=%b exp 1/1/1", m_axis_tvalid, busy, overflow); end
    reset = 1'b1; enable = 1'b0; s_valid = 1'b0;
    cycle();
    reset = 1'b0;
    n_tests++; if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_flags valid=%b busy=%b ovf=%b irq=%b exp all 0", m_axis_tvalid, busy, overflow, irq); end
    n_tests++; if (frame_count !== 16'd0 || m_axis_tdata !== 32'h0 || m_axis_tlast !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_regs fcount=%0d data=%h last=%b exp 0/0/0", frame_count, m_axis_tdata, m_axis_tlast); end
    m_axis_tready = 1'b1; s_valid = 1'b1; s_start = 1'b1; s_data = 32'hF000_00FF;
    cycle();
    s_valid = 1'b0; s_start = 1'b0;
    cycle();
    n_tests++; if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_idle valid=%b busy=%b exp 0/0", m_axis_tvalid, busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len0();
    test_overflow();
    test_enable_drop();
    test_irq_clear();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
